// File: rtl/init_seq_pkg.sv
// Shared state encodings and default timing constants for the init/read sequencer.
// State values are fixed because the 7-segment display decodes them directly.
package init_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_STARTUP    = 4'd1,
    S_INIT_START = 4'd2,
    S_INIT_WAIT  = 4'd3,
    S_READ_START = 4'd4,
    S_READ_WAIT  = 4'd5,
    S_RETRY_GAP  = 4'd6,
    S_NEXT_DEV   = 4'd7
  } state_t;

  localparam int          DEF_DELAY_W       = 29;
  localparam logic [28:0] DEF_STARTUP_DELAY = 29'd50000000;
  localparam logic [28:0] DEF_TXN_TIMEOUT   = 29'd30000;
  localparam logic [28:0] DEF_RETRY_GAP     = 29'd500;
  localparam int          DEF_MAX_RETRY     = 2;

endpackage

// File: rtl/init_seq_ctrl_if.sv
// Start/done handshakes to the per-device init and reg-read engines plus the read request/ack channel.
// master = sequencer side, slave = engines and requester side.
interface init_seq_ctrl_if #(
  parameter int NUM_DEV = 2,
  parameter int DEV_W   = 3
);
  logic [NUM_DEV-1:0] init_start;
  logic [NUM_DEV-1:0] init_done;
  logic               rd_req;
  logic [DEV_W-1:0]   rd_dev_sel;
  logic [NUM_DEV-1:0] rd_start;
  logic [NUM_DEV-1:0] rd_done;
  logic               rd_ack;
  logic               rd_err;

  modport master (
    output init_start, rd_start, rd_ack, rd_err,
    input  init_done, rd_req, rd_dev_sel, rd_done
  );

  modport slave (
    input  init_start, rd_start, rd_ack, rd_err,
    output init_done, rd_req, rd_dev_sel, rd_done
  );
endinterface

// File: rtl/edge_det_vec.sv
// Per-bit rising-edge detector: rise is combinational from the current input against a registered copy.
// A level already high out of reset produces at most one spurious edge in the first cycle.
module edge_det_vec #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= '0;
    else        prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/init_seq_ctrl.sv
// Power-up sequencer: staggered per-device init with timeout/retry, then single-register read service.
// Start pulses and state outputs are decoded from the state; rd_ack/rd_err are registered one cycle after the event.
module init_seq_ctrl
  import init_seq_pkg::*;
#(
  parameter int                 NUM_DEV       = 2,
  parameter int                 DEV_W         = 3,
  parameter int                 DELAY_W       = DEF_DELAY_W,
  parameter logic [DELAY_W-1:0] STARTUP_DELAY = DELAY_W'(DEF_STARTUP_DELAY),
  parameter logic [DELAY_W-1:0] TXN_TIMEOUT   = DELAY_W'(DEF_TXN_TIMEOUT),
  parameter logic [DELAY_W-1:0] RETRY_GAP     = DELAY_W'(DEF_RETRY_GAP),
  parameter int                 MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic               clk,
  input  logic               reset,
  init_seq_ctrl_if.master    bus,
  output logic               busy,
  output logic [NUM_DEV-1:0] init_ok,
  output logic [NUM_DEV-1:0] init_fail,
  output logic               all_ok,
  output logic [3:0]         state_code
);

  localparam logic [DELAY_W-1:0] STARTUP_LAST = STARTUP_DELAY - 1'b1;
  localparam logic [DELAY_W-1:0] TIMEOUT_LAST = TXN_TIMEOUT - 1'b1;
  localparam logic [DELAY_W-1:0] GAP_LAST     = RETRY_GAP - 1'b1;
  localparam logic [2:0]         RETRY_LIM    = 3'(MAX_RETRY);
  localparam logic [DEV_W-1:0]   LAST_DEV     = DEV_W'(NUM_DEV - 1);
  localparam logic [DEV_W:0]     NUM_DEV_X    = (DEV_W+1)'(NUM_DEV);

  state_t             state, state_nxt;
  logic [DELAY_W-1:0] cnt;
  logic [DEV_W-1:0]   dev_idx, rd_idx;
  logic [2:0]         retry_cnt;
  logic [NUM_DEV-1:0] init_rise, rd_rise, dev_oh, rd_oh;
  logic [NUM_DEV-1:0] init_start_c, rd_start_c;
  logic               init_edge, rd_edge, timeout, retry_ok, sel_valid;
  logic               ack_set, err_set, rd_ack_q, rd_err_q;

  edge_det_vec #(.W(NUM_DEV)) u_init_edge (
    .clk  (clk),
    .reset(reset),
    .din  (bus.init_done),
    .rise (init_rise)
  );

  edge_det_vec #(.W(NUM_DEV)) u_rd_edge (
    .clk  (clk),
    .reset(reset),
    .din  (bus.rd_done),
    .rise (rd_rise)
  );

  // Loop-based select keeps index widths independent of NUM_DEV.
  always_comb begin
    dev_oh    = '0;
    rd_oh     = '0;
    init_edge = 1'b0;
    rd_edge   = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (dev_idx == DEV_W'(i)) begin
        dev_oh[i] = 1'b1;
        init_edge = init_rise[i];
      end
      if (rd_idx == DEV_W'(i)) begin
        rd_oh[i] = 1'b1;
        rd_edge  = rd_rise[i];
      end
    end
  end

  assign timeout   = (cnt == TIMEOUT_LAST);
  assign retry_ok  = (retry_cnt < RETRY_LIM);
  assign sel_valid = ({1'b0, bus.rd_dev_sel} < NUM_DEV_X);

  always_comb begin
    state_nxt    = state;
    init_start_c = '0;
    rd_start_c   = '0;
    ack_set      = 1'b0;
    err_set      = 1'b0;
    case (state)
      S_STARTUP: begin
        if (cnt == STARTUP_LAST) state_nxt = S_INIT_START;
      end
      S_INIT_START: begin
        init_start_c = dev_oh;
        state_nxt    = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (init_edge)    state_nxt = S_NEXT_DEV;
        else if (timeout) state_nxt = retry_ok ? S_RETRY_GAP : S_NEXT_DEV;
      end
      S_RETRY_GAP: begin
        if (cnt == GAP_LAST) state_nxt = S_INIT_START;
      end
      S_NEXT_DEV: begin
        state_nxt = (dev_idx == LAST_DEV) ? S_IDLE : S_INIT_START;
      end
      S_IDLE: begin
        if (bus.rd_req) begin
          if (sel_valid) begin
            state_nxt = S_READ_START;
          end else begin
            ack_set = 1'b1;
            err_set = 1'b1;
          end
        end
      end
      S_READ_START: begin
        rd_start_c = rd_oh;
        state_nxt  = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (rd_edge) begin
          ack_set   = 1'b1;
          state_nxt = S_IDLE;
        end else if (timeout) begin
          ack_set   = 1'b1;
          err_set   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_STARTUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_STARTUP;
      cnt       <= '0;
      dev_idx   <= '0;
      rd_idx    <= '0;
      retry_cnt <= '0;
      init_ok   <= '0;
      init_fail <= '0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= (state_nxt != state) ? '0 : cnt + 1'b1;
      rd_ack_q <= ack_set;
      rd_err_q <= err_set;
      case (state)
        S_STARTUP: begin
          if (cnt == STARTUP_LAST) begin
            dev_idx   <= '0;
            retry_cnt <= '0;
          end
        end
        S_INIT_WAIT: begin
          // Edge has priority over a timeout landing on the same cycle.
          if (init_edge) begin
            init_ok <= init_ok | dev_oh;
          end else if (timeout) begin
            if (retry_ok) retry_cnt <= retry_cnt + 1'b1;
            else          init_fail <= init_fail | dev_oh;
          end
        end
        S_NEXT_DEV: begin
          if (dev_idx != LAST_DEV) begin
            dev_idx   <= dev_idx + 1'b1;
            retry_cnt <= '0;
          end
        end
        S_IDLE: begin
          if (bus.rd_req && sel_valid) rd_idx <= bus.rd_dev_sel;
        end
        default: ;
      endcase
    end
  end

  assign bus.init_start = init_start_c;
  assign bus.rd_start   = rd_start_c;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.rd_err     = rd_err_q;
  assign busy           = (state != S_IDLE);
  assign all_ok         = (state == S_IDLE) && (&init_ok);
  assign state_code     = state;

endmodule

// File: tb/tb_init_seq_ctrl.sv
// Bench for init_seq_ctrl: behavioural engine models, start-pulse logging and a read-ack scoreboard.
module tb_init_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy, all_ok;
  logic [1:0] init_ok, init_fail;
  logic [3:0] state_code;

  init_seq_ctrl_if #(.NUM_DEV(2), .DEV_W(3)) sif();

  init_seq_ctrl #(
    .NUM_DEV      (2),
    .DEV_W        (3),
    .DELAY_W      (29),
    .STARTUP_DELAY(29'd10),
    .TXN_TIMEOUT  (29'd20),
    .RETRY_GAP    (29'd5),
    .MAX_RETRY    (2)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (sif.master),
    .busy      (busy),
    .init_ok   (init_ok),
    .init_fail (init_fail),
    .all_ok    (all_ok),
    .state_code(state_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tick = 0;
  int base = 0;
  always @(posedge clk) tick <= tick + 1;

  function automatic int cyc();
    return tick - base;
  endfunction

  typedef struct {
    logic err;
    int   cyc;
  } exp_t;

  typedef struct {
    logic [2:0] sel;
    int         lat;
    int         dly;
    logic       err;
    logic [1:0] mask;
  } rd_vec_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         st0[$];
  int         st1[$];
  int         init_lat[2];
  int         rd_lat[2];
  int         init_cd[2];
  int         rd_cd[2];
  logic [1:0] rd_mask;
  int         rd_cnt, rd_st_cyc, ack_cnt, ack_cyc;
  rd_vec_t    rv[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Engine models and output monitor, evaluated away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sif.init_start[0]) st0.push_back(cyc());
        if (sif.init_start[1]) st1.push_back(cyc());
        if (sif.rd_start != 2'b00) begin
          rd_mask   = rd_mask | sif.rd_start;
          rd_cnt++;
          rd_st_cyc = cyc();
        end
        if (sif.rd_ack) begin
          ack_cnt++;
          ack_cyc = cyc();
          if (sb.size() == 0) begin
            chk("rd_ack expected", sb.size(), 1);
          end else begin
            mon_e = sb.pop_front();
            chk("rd_err", sif.rd_err, mon_e.err);
            chk("rd_ack cycle", cyc(), mon_e.cyc);
          end
        end
        for (int d = 0; d < 2; d++) begin
          if (sif.init_start[d] && init_lat[d] > 0) begin
            sif.init_done[d] = 1'b0;
            init_cd[d]       = init_lat[d];
          end else if (init_cd[d] > 0) begin
            init_cd[d]--;
            if (init_cd[d] == 0) sif.init_done[d] = 1'b1;
          end
          if (sif.rd_start[d] && rd_lat[d] > 0) begin
            sif.rd_done[d] = 1'b0;
            rd_cd[d]       = rd_lat[d];
          end else if (rd_cd[d] > 0) begin
            rd_cd[d]--;
            if (rd_cd[d] == 0) sif.rd_done[d] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk_rst(input string tag);
    chk({tag, " state_code"}, state_code, 1);
    chk({tag, " busy"}, busy, 1);
    chk({tag, " init_ok"}, init_ok, 0);
    chk({tag, " init_fail"}, init_fail, 0);
    chk({tag, " all_ok"}, all_ok, 0);
    chk({tag, " init_start"}, sif.init_start, 0);
    chk({tag, " rd_start"}, sif.rd_start, 0);
    chk({tag, " rd_ack"}, sif.rd_ack, 0);
    chk({tag, " rd_err"}, sif.rd_err, 0);
  endtask

  task automatic do_reset(input int lat0, input int lat1, input logic hold0);
    rst_n          = 1'b0;
    sif.rd_req     = 1'b0;
    sif.rd_dev_sel = 3'd0;
    sif.init_done  = {1'b0, hold0};
    sif.rd_done    = 2'b00;
    init_lat[0] = lat0;
    init_lat[1] = lat1;
    for (int d = 0; d < 2; d++) begin
      init_cd[d] = 0;
      rd_cd[d]   = 0;
      rd_lat[d]  = 0;
    end
    st0.delete();
    st1.delete();
    sb.delete();
    rd_mask = 2'b00;
    rd_cnt  = 0;
    ack_cnt = 0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;
    base  = tick;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc() < n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output int at);
    int n;
    n = 0;
    while (state_code != 4'd0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reach idle", state_code, 0);
    at = cyc();
  endtask

  task automatic send_rd(input logic [2:0] sel, input bit push, input int dly, input logic err);
    exp_t e;
    sif.rd_req     = 1'b1;
    sif.rd_dev_sel = sel;
    if (push) begin
      e.err = err;
      e.cyc = cyc() + dly;
      sb.push_back(e);
    end
    @(negedge clk);
    sif.rd_req = 1'b0;
  endtask

  task automatic wait_ack(input int prev, input int budget);
    int n;
    n = 0;
    while (ack_cnt == prev && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rd_ack arrived", ack_cnt, prev + 1);
  endtask

  initial begin
    int at, a0;
    // {sel, engine latency, req->ack cycles, rd_err, rd_start mask}
    rv[0] = '{3'd1,  7,  9, 1'b0, 2'b10};
    rv[1] = '{3'd3,  0,  1, 1'b1, 2'b00};
    rv[2] = '{3'd0,  2,  4, 1'b0, 2'b01};
    rv[3] = '{3'd0, -1, 22, 1'b1, 2'b01};
    rv[4] = '{3'd7,  0,  1, 1'b1, 2'b00};
    rv[5] = '{3'd1, -1, 22, 1'b1, 2'b10};

    // Both devices respond: first start at cycle 10, second after device 0's edge.
    do_reset(3, 4, 1'b0);
    wait_idle(300, at);
    chk("s1 idle cycle", at, 21);
    chk("s1 dev0 starts", st0.size(), 1);
    chk("s1 dev0 start cycle", st0[0], 10);
    chk("s1 dev1 start cycle", st1[0], 15);
    chk("s1 init_ok", init_ok, 2'b11);
    chk("s1 init_fail", init_fail, 0);
    chk("s1 all_ok", all_ok, 1);
    chk("s1 busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      rd_mask = 2'b00;
      rd_cnt  = 0;
      a0      = ack_cnt;
      if (rv[i].sel < 3'd2) rd_lat[rv[i].sel[0]] = rv[i].lat;
      send_rd(rv[i].sel, 1'b1, rv[i].dly, rv[i].err);
      wait_ack(a0, 60);
      repeat (3) @(negedge clk);
      chk($sformatf("rd_start mask vec%0d", i), rd_mask, rv[i].mask);
      chk($sformatf("busy after vec%0d", i), busy, 0);
    end

    // Timed-out read with a second request issued mid-wait; the second must be dropped.
    rd_lat[0] = -1;
    rd_mask   = 2'b00;
    rd_cnt    = 0;
    a0        = ack_cnt;
    send_rd(3'd0, 1'b1, 22, 1'b1);
    repeat (4) @(negedge clk);
    send_rd(3'd1, 1'b0, 0, 1'b0);
    wait_ack(a0, 60);
    repeat (25) @(negedge clk);
    chk("s5 single ack", ack_cnt, a0 + 1);
    chk("s5 rd_start count", rd_cnt, 1);
    chk("s5 rd_start mask", rd_mask, 2'b01);
    chk("s5 ack after wait entry", ack_cyc - (rd_st_cyc + 1), 20);
    chk("s5 idle", state_code, 0);

    // Device 1 never responds: three attempts 26 cycles apart, then fail.
    do_reset(3, -1, 1'b0);
    wait_idle(300, at);
    chk("s2 idle cycle", at, 89);
    chk("s2 dev1 starts", st1.size(), 3);
    chk("s2 dev1 first", st1[0], 15);
    chk("s2 gap1", st1[1] - st1[0], 26);
    chk("s2 gap2", st1[2] - st1[1], 26);
    chk("s2 dev0 starts", st0.size(), 1);
    chk("s2 init_fail", init_fail, 2'b10);
    chk("s2 init_ok", init_ok, 2'b01);
    chk("s2 all_ok", all_ok, 0);
    chk("s2 busy", busy, 0);

    // Stale-high done on device 0: first attempt times out, fresh edge in the second passes.
    do_reset(-1, 4, 1'b1);
    wait_cyc(38);
    chk("s3 no early ok", init_ok, 0);
    sif.init_done[0] = 1'b0;
    wait_cyc(39);
    sif.init_done[0] = 1'b1;
    wait_idle(300, at);
    chk("s3 idle cycle", at, 47);
    chk("s3 dev0 starts", st0.size(), 2);
    chk("s3 dev0 retry start", st0[1], 36);
    chk("s3 dev1 start", st1[0], 41);
    chk("s3 init_ok", init_ok, 2'b11);
    chk("s3 init_fail", init_fail, 0);

    // Asynchronous reset while waiting on device 1, then full restart.
    do_reset(3, -1, 1'b0);
    wait_cyc(20);
    chk("s6 in init_wait", state_code, 3);
    chk("s6 dev0 ok before reset", init_ok, 2'b01);
    #1 rst_n = 1'b0;
    #1 chk_rst("s6 async");
    repeat (2) @(negedge clk);
    st0.delete();
    st1.delete();
    rst_n = 1'b1;
    base  = tick;
    wait_cyc(9);
    chk("s6 still startup", state_code, 1);
    chk("s6 no early start", st0.size(), 0);
    wait_cyc(10);
    chk("s6 restart start count", st0.size(), 1);
    chk("s6 restart start cycle", st0[0], 10);

    chk("scoreboard drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
